// File: rtl/timer_pkg.sv
// Shared encodings, limits and helpers for the countdown timer controller.
package timer_pkg;

    typedef enum logic [2:0] {
        S_SET_SEC = 3'd0,
        S_SET_MIN = 3'd1,
        S_STOPPED = 3'd2,
        S_RUNNING = 3'd3,
        S_FLASH   = 3'd4
    } state_t;

    localparam logic [7:0] MAX_SEC = 8'd59;
    localparam logic [7:0] MAX_MIN = 8'd99;
    localparam logic [9:0] LED_ALL = 10'h3FF;

    // Saturate a raw switch value to the largest legal field value.
    function automatic logic [7:0] clamp_sw(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/timer_if.sv
// Board-side signal bundle for the timer controller: raw keys and switches in,
// display values and status out.
interface timer_if;
    logic       set_n;
    logic       toggle_n;
    logic [7:0] sw;
    logic [6:0] min_out;
    logic [5:0] sec_out;
    logic [2:0] state_out;
    logic       blank;
    logic [9:0] led_out;

    modport master (
        output set_n, toggle_n, sw,
        input  min_out, sec_out, state_out, blank, led_out
    );

    modport slave (
        input  set_n, toggle_n, sw,
        output min_out, sec_out, state_out, blank, led_out
    );
endinterface

// File: rtl/key_pulse.sv
// Pushbutton conditioner: two-stage synchroniser, stable-low debounce timer and
// a single-cycle pulse per accepted press. Holding the key yields one pulse;
// the key must be seen released before it can fire again.
module key_pulse #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int            CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYC - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;
    logic          fired;

    // Bring the raw key into the clock domain; idle level is high (released).
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
        end
    end

    // Down-count while held low; terminal count fires once, release re-arms.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cnt   <= CNT_LOAD;
            fired <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b) begin
                cnt   <= CNT_LOAD;
                fired <= 1'b0;
            end else if (!fired) begin
                if (cnt == '0) begin
                    press <= 1'b1;
                    fired <= 1'b1;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: loads seconds then minutes from the switches,
// runs a 1 Hz countdown on demand and flashes the display at 00:00.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   S_SET_SEC | seconds track switches (clamped to 59)
//   S_SET_MIN | minutes track switches (clamped to 99)
//   S_STOPPED | time held; toggle starts, set re-enters setup
//   S_RUNNING | tick prescaler decrements time once per period
//   S_FLASH   | 00:00 reached; display and LEDs blink
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int FLASH_DIV    = 12_500_000,
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic    CLOCK_50,
    input  logic    reset,
    timer_if.slave  bus
);
    localparam int            TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int            FW         = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [TW-1:0] TICK_LOAD  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_DIV - 1);

    logic set_p;
    logic toggle_p;

    state_t        state_q,   state_nx;
    logic [6:0]    min_q,     min_nx;
    logic [5:0]    sec_q,     sec_nx;
    logic [TW-1:0] tick_q,    tick_nx;
    logic [FW-1:0] flash_q,   flash_nx;
    logic          blank_q,   blank_nx;
    logic [9:0]    led_q,     led_nx;

    key_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_set_key (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (bus.set_n),
        .press    (set_p)
    );

    key_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_toggle_key (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (bus.toggle_n),
        .press    (toggle_p)
    );

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) state_q <= S_SET_SEC;
        else        state_q <= state_nx;
    end

    // Time, prescaler and output registers.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            min_q   <= '0;
            sec_q   <= '0;
            tick_q  <= TICK_LOAD;
            flash_q <= FLASH_LOAD;
            blank_q <= 1'b0;
            led_q   <= 10'h001;
        end else begin
            min_q   <= min_nx;
            sec_q   <= sec_nx;
            tick_q  <= tick_nx;
            flash_q <= flash_nx;
            blank_q <= blank_nx;
            led_q   <= led_nx;
        end
    end

    // Next state, time arithmetic, prescalers and LED/blank drive.
    always_comb begin
        state_nx = state_q;
        min_nx   = min_q;
        sec_nx   = sec_q;
        tick_nx  = tick_q;
        flash_nx = flash_q;
        blank_nx = blank_q;
        led_nx   = led_q;

        case (state_q)
            S_SET_SEC: begin
                if (set_p) state_nx = S_SET_MIN;
                else       sec_nx   = 6'(clamp_sw(bus.sw, MAX_SEC));
            end
            S_SET_MIN: begin
                if (set_p) state_nx = S_STOPPED;
                else       min_nx   = 7'(clamp_sw(bus.sw, MAX_MIN));
            end
            S_STOPPED: begin
                // set wins when both keys land in the same cycle
                if (set_p) begin
                    state_nx = S_SET_SEC;
                end else if (toggle_p) begin
                    if (min_q == '0 && sec_q == '0) state_nx = S_FLASH;
                    else                            state_nx = S_RUNNING;
                end
            end
            S_RUNNING: begin
                // a stop request suppresses a coincident tick
                if (toggle_p) begin
                    state_nx = S_STOPPED;
                end else if (tick_q == '0) begin
                    tick_nx = TICK_LOAD;
                    if (sec_q != '0) begin
                        sec_nx = sec_q - 6'd1;
                        if (sec_q == 6'd1 && min_q == '0) state_nx = S_FLASH;
                    end else if (min_q != '0) begin
                        sec_nx = 6'(MAX_SEC);
                        min_nx = min_q - 7'd1;
                    end
                end else begin
                    tick_nx = tick_q - TW'(1);
                end
            end
            S_FLASH: begin
                if (set_p) begin
                    state_nx = S_SET_SEC;
                end else if (flash_q == '0) begin
                    flash_nx = FLASH_LOAD;
                    blank_nx = ~blank_q;
                end else begin
                    flash_nx = flash_q - FW'(1);
                end
            end
            default: state_nx = S_SET_SEC;
        endcase

        // Every state change restarts both prescalers and unblanks the display.
        if (state_nx != state_q) begin
            tick_nx  = TICK_LOAD;
            flash_nx = FLASH_LOAD;
            blank_nx = 1'b0;
        end

        if (state_nx == S_FLASH) led_nx = blank_nx ? '0 : LED_ALL;
        else                     led_nx = 10'd1 << state_nx;
    end

    assign bus.min_out   = min_q;
    assign bus.sec_out   = sec_q;
    assign bus.state_out = state_q;
    assign bus.blank     = blank_q;
    assign bus.led_out   = led_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with short divisors (tick 10, flash 4, debounce 3).
// A key held low from just after edge N is accepted by the FSM on edge N+6.
module tb_timer_ctrl;
    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    timer_if bus ();

    timer_ctrl #(.TICK_DIV(10), .FLASH_DIV(4), .DEBOUNCE_CYC(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Holds the chosen keys for 6 edges; returns 1 ns after the accepting edge.
    task automatic press(input bit s, input bit t);
        if (s) bus.set_n = 1'b0;
        if (t) bus.toggle_n = 1'b0;
        cyc(6);
        bus.set_n    = 1'b1;
        bus.toggle_n = 1'b1;
    endtask

    // From SET_SEC: load seconds then minutes, ending in STOPPED.
    task automatic load_time(input logic [7:0] m, input logic [7:0] s);
        bus.sw = s;
        cyc(3);
        press(1, 0);
        bus.sw = m;
        cyc(3);
        press(1, 0);
    endtask

    task automatic test_reset;
        bus.set_n = 1'b1; bus.toggle_n = 1'b1; bus.sw = 8'd0;
        cyc(3);
        n_cmp++; if (bus.state_out !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", bus.state_out); end
        n_cmp++; if (bus.led_out !== 10'h001) begin n_bad++; $display("FAIL rst_led: got %h want 001", bus.led_out); end
        n_cmp++; if (bus.min_out !== 7'd0 || bus.sec_out !== 6'd0 || bus.blank !== 1'b0) begin
            n_bad++; $display("FAIL rst_time: got %0d:%0d blank %b want 0:0 blank 0", bus.min_out, bus.sec_out, bus.blank); end
        reset = 1'b1;
        cyc(2);
    endtask

    task automatic test_load;
        bus.sw = 8'd75;
        cyc(2);
        n_cmp++; if (bus.sec_out !== 6'd59) begin n_bad++; $display("FAIL load_sec_clamp: got %0d want 59", bus.sec_out); end
        press(1, 0);
        n_cmp++; if (bus.state_out !== 3'd1) begin n_bad++; $display("FAIL load_to_min: got %0d want 1", bus.state_out); end
        bus.sw = 8'd200;
        cyc(2);
        n_cmp++; if (bus.min_out !== 7'd99) begin n_bad++; $display("FAIL load_min_clamp: got %0d want 99", bus.min_out); end
        bus.sw = 8'd2;
        cyc(2);
        n_cmp++; if (bus.min_out !== 7'd2) begin n_bad++; $display("FAIL load_min: got %0d want 2", bus.min_out); end
        press(1, 0);
        n_cmp++; if (bus.state_out !== 3'd2 || bus.sec_out !== 6'd59 || bus.min_out !== 7'd2) begin
            n_bad++; $display("FAIL load_done: got st %0d %0d:%0d want st 2 2:59", bus.state_out, bus.min_out, bus.sec_out); end
        n_cmp++; if (bus.led_out !== 10'h004) begin n_bad++; $display("FAIL load_led: got %h want 004", bus.led_out); end
    endtask

    task automatic test_debounce;
        cyc(3);
        bus.toggle_n = 1'b0;
        cyc(2);
        bus.toggle_n = 1'b1;
        cyc(10);
        n_cmp++; if (bus.state_out !== 3'd2) begin n_bad++; $display("FAIL deb_glitch: got %0d want 2", bus.state_out); end
        bus.toggle_n = 1'b0;
        cyc(20);
        bus.toggle_n = 1'b1;
        cyc(4);
        n_cmp++; if (bus.state_out !== 3'd3) begin n_bad++; $display("FAIL deb_hold: got %0d want 3", bus.state_out); end
        n_cmp++; if (bus.led_out !== 10'h008) begin n_bad++; $display("FAIL run_led: got %h want 008", bus.led_out); end
        cyc(3);
        press(0, 1);
        n_cmp++; if (bus.state_out !== 3'd2) begin n_bad++; $display("FAIL deb_stop: got %0d want 2", bus.state_out); end
    endtask

    task automatic test_simultaneous;
        cyc(3);
        press(1, 1);
        n_cmp++; if (bus.state_out !== 3'd0) begin n_bad++; $display("FAIL both_keys_stopped: got %0d want 0", bus.state_out); end
    endtask

    task automatic test_countdown;
        load_time(8'd0, 8'd3);
        cyc(3);
        press(0, 1);
        n_cmp++; if (bus.state_out !== 3'd3 || bus.sec_out !== 6'd3) begin
            n_bad++; $display("FAIL cd_start: got st %0d sec %0d want st 3 sec 3", bus.state_out, bus.sec_out); end
        cyc(9);
        n_cmp++; if (bus.sec_out !== 6'd3) begin n_bad++; $display("FAIL cd_early: got %0d want 3", bus.sec_out); end
        cyc(1);
        n_cmp++; if (bus.sec_out !== 6'd2) begin n_bad++; $display("FAIL cd_tick1: got %0d want 2", bus.sec_out); end
        cyc(10);
        n_cmp++; if (bus.sec_out !== 6'd1) begin n_bad++; $display("FAIL cd_tick2: got %0d want 1", bus.sec_out); end
        cyc(9);
        n_cmp++; if (bus.state_out !== 3'd3) begin n_bad++; $display("FAIL cd_before_zero: got %0d want 3", bus.state_out); end
        cyc(1);
        n_cmp++; if (bus.state_out !== 3'd4 || bus.sec_out !== 6'd0 || bus.min_out !== 7'd0) begin
            n_bad++; $display("FAIL cd_zero: got st %0d %0d:%0d want st 4 0:0", bus.state_out, bus.min_out, bus.sec_out); end
    endtask

    // Entered at the FLASH entry edge (F0).
    task automatic test_flash;
        n_cmp++; if (bus.led_out !== 10'h3FF || bus.blank !== 1'b0) begin
            n_bad++; $display("FAIL fl_f0: got led %h blank %b want 3ff 0", bus.led_out, bus.blank); end
        cyc(3);
        n_cmp++; if (bus.led_out !== 10'h3FF || bus.blank !== 1'b0) begin
            n_bad++; $display("FAIL fl_f3: got led %h blank %b want 3ff 0", bus.led_out, bus.blank); end
        cyc(1);
        n_cmp++; if (bus.led_out !== 10'h000 || bus.blank !== 1'b1) begin
            n_bad++; $display("FAIL fl_f4: got led %h blank %b want 000 1", bus.led_out, bus.blank); end
        cyc(3);
        n_cmp++; if (bus.led_out !== 10'h000 || bus.blank !== 1'b1) begin
            n_bad++; $display("FAIL fl_f7: got led %h blank %b want 000 1", bus.led_out, bus.blank); end
        cyc(1);
        n_cmp++; if (bus.led_out !== 10'h3FF || bus.blank !== 1'b0) begin
            n_bad++; $display("FAIL fl_f8: got led %h blank %b want 3ff 0", bus.led_out, bus.blank); end
        press(0, 1);
        n_cmp++; if (bus.state_out !== 3'd4 || bus.blank !== 1'b1) begin
            n_bad++; $display("FAIL fl_toggle_ignored: got st %0d blank %b want st 4 blank 1", bus.state_out, bus.blank); end
        cyc(4);
        press(1, 0);
        n_cmp++; if (bus.state_out !== 3'd0 || bus.blank !== 1'b0 || bus.led_out !== 10'h001) begin
            n_bad++; $display("FAIL fl_exit: got st %0d blank %b led %h want st 0 blank 0 led 001", bus.state_out, bus.blank, bus.led_out); end
    endtask

    task automatic test_borrow_stop;
        load_time(8'd1, 8'd0);
        cyc(3);
        press(0, 1);
        cyc(10);
        n_cmp++; if (bus.min_out !== 7'd0 || bus.sec_out !== 6'd59 || bus.state_out !== 3'd3) begin
            n_bad++; $display("FAIL borrow: got st %0d %0d:%0d want st 3 0:59", bus.state_out, bus.min_out, bus.sec_out); end
        cyc(4);
        press(0, 1);
        n_cmp++; if (bus.state_out !== 3'd2 || bus.sec_out !== 6'd59 || bus.min_out !== 7'd0) begin
            n_bad++; $display("FAIL stop_on_tick: got st %0d %0d:%0d want st 2 0:59", bus.state_out, bus.min_out, bus.sec_out); end
        cyc(12);
        n_cmp++; if (bus.sec_out !== 6'd59) begin n_bad++; $display("FAIL stopped_hold: got %0d want 59", bus.sec_out); end
    endtask

    task automatic test_zero_start;
        cyc(3);
        press(1, 0);
        load_time(8'd0, 8'd0);
        cyc(3);
        press(0, 1);
        n_cmp++; if (bus.state_out !== 3'd4) begin n_bad++; $display("FAIL zero_start: got %0d want 4", bus.state_out); end
        cyc(3);
        press(1, 0);
    endtask

    task automatic test_async_reset;
        load_time(8'd1, 8'd30);
        cyc(3);
        press(0, 1);
        cyc(12);
        n_cmp++; if (bus.min_out !== 7'd1 || bus.sec_out !== 6'd29) begin
            n_bad++; $display("FAIL pre_reset: got %0d:%0d want 1:29", bus.min_out, bus.sec_out); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.state_out !== 3'd0 || bus.min_out !== 7'd0 || bus.sec_out !== 6'd0 ||
                     bus.blank !== 1'b0 || bus.led_out !== 10'h001) begin
            n_bad++; $display("FAIL async_reset: got st %0d %0d:%0d blank %b led %h want st 0 0:0 blank 0 led 001",
                              bus.state_out, bus.min_out, bus.sec_out, bus.blank, bus.led_out); end
        cyc(2);
        reset = 1'b1;
        cyc(3);
        n_cmp++; if (bus.state_out !== 3'd0) begin n_bad++; $display("FAIL post_reset: got %0d want 0", bus.state_out); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_debounce();
        test_simultaneous();
        test_countdown();
        test_flash();
        test_borrow_stop();
        test_zero_start();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
